uart_debug_master: RTL and testbench
====================================

# uart_debug_master

Bus initiator driven by a UART byte stream: the other end of the UART peripheral's bus interface. It parses framed read/write commands from the byte output of a UART receiver, issues single-word bus_protocol_if transactions, and returns a status byte plus read data through a UART transmitter. It sits between a UartRxEn/UartTxEn pair and the system bus, and gives an external host debug access to memory-mapped space, including the UART peripheral registers.

## Interface
- TIMEOUT_CYCLES, 1024: bus watchdog limit in cycles. Only used with UART_DBG_TIMEOUT_EN.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse; a received byte is present on rx_data. There is no backpressure.
- rx_data  in  8  received byte.
- rx_err  in  1  framing error qualifier for the same cycle as rx_valid.
- tx_valid  out  1  a response byte is valid.
- tx_data  out  8  response byte.
- tx_ready  in  1  the transmitter accepts tx_data.
- bus_addr  out  32  transaction address.
- bus_wen  out  1  write request.
- bus_ren  out  1  read request.
- bus_wdata  out  32  write data.
- bus_strobe  out  4  byte enables; always 4'hF during a request.
- bus_rdata  in  32  read data.
- bus_request_stall  in  1  the responder is not done.
- bus_error  in  1  the responder reports an error on the completing cycle.
- dropped  out  1  sticky flag: a byte arrived while busy. Cleared by reset or by an accepted 'W'/'R' opcode.
- busy  out  1  the block is in any state other than IDLE.

## Operation
- Frame formats:
  - Write: 0x57 'W', A0..A3, D0..D3.
  - Read: 0x52 'R', A0..A3.
  - Address and data are sent little-endian (A0 = addr[7:0]).
- Response: one status byte, followed by D0..D3 only for a read whose status is 0x00.
- Status codes: 0x00 OK, 0x01 bus_error, 0x02 timeout, 0x03 misaligned (addr[1:0]≠0, no bus access), 0xEE unknown opcode.
- States and transitions:
  - IDLE to ADDR on an opcode byte 'W'/'R'.
  - Any other opcode byte: queue status 0xEE, go to RESP.
  - ADDR collects 4 bytes. Then DATA (write), BUS (read), or RESP with 0x03 if misaligned.
  - DATA collects 4 bytes, then BUS.
  - BUS drives the request until completion, then RESP.
  - RESP sends 1 or 5 bytes, then IDLE.
- A byte with rx_valid and rx_err set is discarded in every state. The frame aborts to IDLE silently, with no response.
- An rx_valid pulse in BUS or RESP is dropped and sets dropped. The state is unchanged.
- Byte counters are 2-bit and wrap from 3 to 0 on the last byte. The address and data registers shift in bytes at the MSB end.

## Timing
- Reset values:
  - tx_valid=0, tx_data=0.
  - bus_wen=0, bus_ren=0, bus_addr=0, bus_wdata=0, bus_strobe=0.
  - dropped=0, busy=0, state=IDLE.
- The bus request asserts the cycle after the last frame byte is accepted.
- bus_addr, bus_wdata, bus_wen/bus_ren and bus_strobe are held constant while bus_request_stall=1.
- The transaction completes on the first cycle with bus_request_stall=0:
  - bus_rdata and bus_error are captured on that cycle.
  - Requests deassert on the next cycle.
  - A zero-stall access therefore occupies exactly one cycle.
- The first response byte presents tx_valid the cycle after completion.
- Response handshake:
  - tx_data is stable while tx_valid=1 and tx_ready=0.
  - A byte transfers on a cycle with tx_valid and tx_ready both 1.
  - The next byte is presented the following cycle.
- After the final transfer: tx_valid=0 and the state is IDLE on the next cycle. A new opcode is accepted on that cycle.
- Reset mid-transaction drops requests immediately (asynchronous). No response is sent.
- Misaligned and unknown-opcode responses start the cycle after the offending byte.

## Configuration
- UART_DBG_TIMEOUT_EN defined:
  - A 16-bit counter runs in BUS and clears on entry.
  - If it reaches TIMEOUT_CYCLES with bus_request_stall still 1: requests deassert, status is 0x02, go to RESP with no data bytes.
- Undefined: no counter, and BUS waits indefinitely. Status 0x02 is never produced.

## Structure
- Package uart_debug_pkg holds:
  - the state enum (IDLE, ADDR, DATA, BUS, RESP);
  - opcode constants OP_WRITE=8'h57, OP_READ=8'h52;
  - status constants ST_OK, ST_BUSERR, ST_TIMEOUT, ST_MISALIGN, ST_BADOP.
- Single module; no sub-module. The UART Rx/Tx and baud generation are instantiated by the parent.

## Test plan
- Write: frame 57 10 00 00 00 EF BE AD DE, zero stall. Required: one cycle with bus_wen=1, addr 0x10, wdata 0xDEADBEEF; response 00.
- Read with stall: frame 52 04 00 00 00, stall held 3 cycles, rdata 0x11223344. Required: request held 4 cycles; response 00 44 33 22 11.
- Responder error and backpressure: bus_error=1 on the completion cycle of a read, tx_ready toggling every other cycle. Required: response is the single byte 01; tx_data stable while stalled.
- Misaligned and bad opcode: frame 52 02 00 00 00 gives no bus access and response 03. Byte 0x41 gives response EE.
- Dropped and framing error:
  - A byte during BUS sets dropped=1; the following 'R' opcode clears it.
  - rx_err mid-frame returns to IDLE with no tx.
- Timeout and reset (UART_DBG_TIMEOUT_EN, TIMEOUT_CYCLES=8): permanent stall gives requests deasserted after 8 cycles and response 02. Reset asserted in BUS gives all outputs 0 immediately.

Source files
------------

// File: rtl/uart_debug_pkg.sv
// Shared types and constants for the UART-driven debug bus master.
package uart_debug_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  localparam logic [7:0] OP_WRITE    = 8'h57;
  localparam logic [7:0] OP_READ     = 8'h52;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BUSERR   = 8'h01;
  localparam logic [7:0] ST_TIMEOUT  = 8'h02;
  localparam logic [7:0] ST_MISALIGN = 8'h03;
  localparam logic [7:0] ST_BADOP    = 8'hEE;
endpackage

// File: rtl/uart_debug_master.sv
// UART byte-stream to single-word bus initiator with status/read-data response.
// Optional bus watchdog enabled by defining UART_DBG_TIMEOUT_EN.
module uart_debug_master
  import uart_debug_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_err,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [31:0] bus_addr,
  output logic        bus_wen,
  output logic        bus_ren,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_strobe,
  input  logic [31:0] bus_rdata,
  input  logic        bus_request_stall,
  input  logic        bus_error,
  output logic        dropped,
  output logic        busy
);

  state_t      state_q, state_n;
  logic [1:0]  cnt_q, cnt_n;
  logic        is_wr_q, is_wr_n;
  logic [31:0] addr_q, addr_n, wdata_q, wdata_n, rdata_q, rdata_n;
  logic [2:0]  idx_q, idx_n, last_q, last_n;
  logic        dropped_n, tx_valid_n, wen_n, ren_n;
  logic [7:0]  tx_data_n;
  logic [3:0]  strobe_n;
  logic [31:0] baddr_n, bwdata_n;
  logic [31:0] addr_sh, data_sh;
  logic        rx_ok, to_hit;

`ifdef UART_DBG_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q;

  // Zero outside BUS, so it is already clear on the entry cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               to_cnt_q <= '0;
    else if (state_q != BUS) to_cnt_q <= '0;
    else                     to_cnt_q <= to_cnt_q + 16'd1;
  end
  assign to_hit = (to_cnt_q == TO_LAST);
`else
  logic [31:0] unused_to;
  assign unused_to = TIMEOUT_CYCLES;
  assign to_hit    = 1'b0;
`endif

  assign busy    = (state_q != IDLE);
  assign rx_ok   = rx_valid && !rx_err;
  assign addr_sh = {rx_data, addr_q[31:8]};
  assign data_sh = {rx_data, wdata_q[31:8]};

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    is_wr_n    = is_wr_q;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    rdata_n    = rdata_q;
    idx_n      = idx_q;
    last_n     = last_q;
    dropped_n  = dropped;
    tx_valid_n = tx_valid;
    tx_data_n  = tx_data;
    wen_n      = bus_wen;
    ren_n      = bus_ren;
    strobe_n   = bus_strobe;
    baddr_n    = bus_addr;
    bwdata_n   = bus_wdata;
    case (state_q)
      IDLE: if (rx_ok) begin
        if (rx_data == OP_WRITE || rx_data == OP_READ) begin
          state_n   = ADDR;
          cnt_n     = 2'd0;
          is_wr_n   = (rx_data == OP_WRITE);
          dropped_n = 1'b0;
        end else begin
          state_n    = RESP;
          tx_valid_n = 1'b1;
          tx_data_n  = ST_BADOP;
          idx_n      = 3'd0;
          last_n     = 3'd0;
        end
      end
      ADDR: if (rx_valid && rx_err) begin
        state_n = IDLE;
      end else if (rx_valid) begin
        addr_n = addr_sh;
        cnt_n  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          if (addr_sh[1:0] != 2'b00) begin
            state_n    = RESP;
            tx_valid_n = 1'b1;
            tx_data_n  = ST_MISALIGN;
            idx_n      = 3'd0;
            last_n     = 3'd0;
          end else if (is_wr_q) begin
            state_n = DATA;
          end else begin
            state_n  = BUS;
            ren_n    = 1'b1;
            strobe_n = 4'hF;
            baddr_n  = addr_sh;
          end
        end
      end
      DATA: if (rx_valid && rx_err) begin
        state_n = IDLE;
      end else if (rx_valid) begin
        wdata_n = data_sh;
        cnt_n   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_n  = BUS;
          wen_n    = 1'b1;
          strobe_n = 4'hF;
          baddr_n  = addr_q;
          bwdata_n = data_sh;
        end
      end
      BUS: begin
        if (rx_ok) dropped_n = 1'b1;
        if (!bus_request_stall) begin
          wen_n      = 1'b0;
          ren_n      = 1'b0;
          strobe_n   = 4'h0;
          state_n    = RESP;
          tx_valid_n = 1'b1;
          idx_n      = 3'd0;
          rdata_n    = bus_rdata;
          if (bus_error) begin
            tx_data_n = ST_BUSERR;
            last_n    = 3'd0;
          end else begin
            tx_data_n = ST_OK;
            last_n    = is_wr_q ? 3'd0 : 3'd4;
          end
        end else if (to_hit) begin
          wen_n      = 1'b0;
          ren_n      = 1'b0;
          strobe_n   = 4'h0;
          state_n    = RESP;
          tx_valid_n = 1'b1;
          tx_data_n  = ST_TIMEOUT;
          idx_n      = 3'd0;
          last_n     = 3'd0;
        end
      end
      RESP: begin
        if (rx_ok) dropped_n = 1'b1;
        if (tx_valid && tx_ready) begin
          if (idx_q == last_q) begin
            tx_valid_n = 1'b0;
            state_n    = IDLE;
          end else begin
            // Byte idx_q+1 of the response is read-data byte idx_q.
            idx_n     = idx_q + 3'd1;
            tx_data_n = rdata_q[{idx_q[1:0], 3'b000} +: 8];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      dropped    <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      bus_wen    <= 1'b0;
      bus_ren    <= 1'b0;
      bus_strobe <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      is_wr_q    <= is_wr_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      rdata_q    <= rdata_n;
      idx_q      <= idx_n;
      last_q     <= last_n;
      dropped    <= dropped_n;
      tx_valid   <= tx_valid_n;
      tx_data    <= tx_data_n;
      bus_wen    <= wen_n;
      bus_ren    <= ren_n;
      bus_strobe <= strobe_n;
      bus_addr   <= baddr_n;
      bus_wdata  <= bwdata_n;
    end
  end

endmodule

// File: tb/tb_uart_debug_master.sv
// Scoreboard bench for uart_debug_master: random frames against a memory-level model.
module tb_uart_debug_master;
  localparam int TO = 8;
  localparam logic [7:0] W = 8'h57, R = 8'h52;

  logic clk = 1'b0, reset;
  logic rx_valid, rx_err, tx_valid, tx_ready, bus_wen, bus_ren;
  logic bus_request_stall, bus_error, dropped, busy;
  logic [7:0] rx_data, tx_data;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0] bus_strobe;

  always #5 clk = ~clk;

  uart_debug_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_wdata(bus_wdata),
    .bus_strobe(bus_strobe), .bus_rdata(bus_rdata), .bus_request_stall(bus_request_stall),
    .bus_error(bus_error), .dropped(dropped), .busy(busy));

  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; } bus_t;

  int checks = 0, errors = 0;
  logic [7:0] exp_tx[$];
  bus_t exp_bus[$];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] resp_mem[logic [31:0]];
  int force_rem = -1;
  bit rdy_toggle = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : (a ^ 32'h5A5A1234);
  endfunction

  function automatic logic [31:0] resp_rd(input logic [31:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : (a ^ 32'h5A5A1234);
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic e = 1'b0);
    @(negedge clk); rx_valid = 1'b1; rx_data = b; rx_err = e;
    @(negedge clk); rx_valid = 1'b0; rx_err = 1'b0;
  endtask

  // Pushes the expected bus access and response, then sends the frame.
  task automatic send_frame(input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] d, input bit clr = 0);
    logic [7:0] st;
    bit wr;
    wr = (op == W);
    if (op != W && op != R) begin
      exp_tx.push_back(8'hEE);
      send_byte(op);
      chk("badop_latency", tx_valid, 1);
      return;
    end
    if (a[1:0] != 2'b00) begin
      exp_tx.push_back(8'h03);
    end else begin
      exp_bus.push_back('{a, wr, d});
      st = (a[7:4] == 4'hF) ? 8'h01 : 8'h00;
`ifdef UART_DBG_TIMEOUT_EN
      if (force_rem >= TO) st = 8'h02;
`endif
      exp_tx.push_back(st);
      if (st == 8'h00 && wr) model_mem[a] = d;
      if (st == 8'h00 && !wr)
        for (int i = 0; i < 4; i++) exp_tx.push_back(8'((model_rd(a) >> (8 * i))));
    end
    send_byte(op);
    if (clr) chk("dropped_clear", dropped, 0);
    for (int i = 0; i < 4; i++) send_byte(8'(a >> (8 * i)));
    if (a[1:0] != 2'b00) begin
      chk("misalign_latency", tx_valid, 1);
      return;
    end
    if (wr) for (int i = 0; i < 4; i++) send_byte(8'(d >> (8 * i)));
    chk("req_latency", bus_wen | bus_ren, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) chk("idle_bound", busy, 0);
    chk("tx_drained", exp_tx.size(), 0);
    chk("bus_drained", exp_bus.size(), 0);
  endtask

  // Bus responder: stall count chosen per access, data from its own memory.
  initial begin
    bit in_tx = 0;
    int rem = 0, cyc = 0, exp_cyc = 0;
    logic [31:0] ha, hd;
    logic hw, hr;
    logic [3:0] hs;
    bus_t cur;
    bus_request_stall = 1'b0; bus_error = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_tx = 0;
      end else if (bus_wen || bus_ren) begin
        if (!in_tx) begin
          in_tx = 1; cyc = 0;
          rem = (force_rem >= 0) ? force_rem : $urandom_range(0, 3);
          exp_cyc = rem + 1;
`ifdef UART_DBG_TIMEOUT_EN
          if (exp_cyc > TO) exp_cyc = TO;
`endif
          ha = bus_addr; hd = bus_wdata; hw = bus_wen; hr = bus_ren; hs = bus_strobe;
          if (exp_bus.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected: got addr %0h with no access expected", bus_addr);
          end else begin
            cur = exp_bus.pop_front();
            chk("bus_addr", bus_addr, cur.addr);
            chk("bus_dir", {bus_wen, bus_ren}, {cur.wr, !cur.wr});
            if (cur.wr) chk("bus_wdata", bus_wdata, cur.wdata);
          end
          chk("bus_strobe", bus_strobe, 4'hF);
        end else begin
          chk("bus_hold", {bus_addr, bus_wdata, bus_wen, bus_ren, bus_strobe}, {ha, hd, hw, hr, hs});
        end
        cyc++;
        if (rem > 0) begin
          bus_request_stall = 1'b1; rem--;
          bus_error = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
        end else begin
          bus_request_stall = 1'b0;
          bus_error = (bus_addr[7:4] == 4'hF);
          bus_rdata = bus_wen ? $urandom : resp_rd(bus_addr);
          if (bus_wen && !bus_error) resp_mem[bus_addr] = bus_wdata;
        end
      end else begin
        if (in_tx) begin
          chk("bus_cycles", cyc, exp_cyc);
          chk("tx_after_bus", tx_valid, 1);
          in_tx = 0;
        end
        bus_request_stall = 1'($urandom_range(0, 1));
        bus_error = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
    end
  end

  // Response monitor: random backpressure, pops expected bytes on transfer.
  initial begin
    logic [7:0] pd = '0;
    bit pstall = 0;
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pstall = 0;
      end else begin
        if (pstall) chk("tx_stable", {tx_valid, tx_data}, {1'b1, pd});
        pstall = 0;
        if (tx_valid) begin
          tx_ready = rdy_toggle ? ~tx_ready : 1'($urandom_range(0, 1));
          if (tx_ready) begin
            if (exp_tx.size() == 0) begin
              checks++; errors++;
              $display("FAIL tx_unexpected: got byte %0h with none expected", tx_data);
            end else chk("tx_byte", tx_data, exp_tx.pop_front());
          end else begin
            pstall = 1; pd = tx_data;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int op, nb;
    model_mem[32'h4] = 32'h11223344;
    resp_mem[32'h4]  = 32'h11223344;
    rx_valid = 1'b0; rx_err = 1'b0; rx_data = '0;
    reset = 1'b1;
    #3;
    chk("rst_tx", {tx_valid, tx_data}, 0);
    chk("rst_bus", {bus_wen, bus_ren, bus_addr, bus_wdata, bus_strobe}, 0);
    chk("rst_flags", {dropped, busy}, 0);
    @(negedge clk); reset = 1'b0;

    // Directed test-plan frames.
    force_rem = 0;
    send_frame(W, 32'h10, 32'hDEADBEEF); wait_idle();
    force_rem = 3;
    send_frame(R, 32'h4, 0); wait_idle();
    force_rem = -1; rdy_toggle = 1;
    send_frame(R, 32'hF0, 0); wait_idle();
    rdy_toggle = 0;
    send_frame(R, 32'h2, 0); wait_idle();
    send_frame(8'h41, 0, 0); wait_idle();

    // Byte during BUS sets dropped; next opcode clears it.
    force_rem = 5;
    send_frame(R, 32'h20, 0);
    send_byte(8'h33);
    wait_idle();
    chk("dropped_set", dropped, 1);
    force_rem = -1;
    send_frame(R, 32'h10, 0, 1); wait_idle();

    // Framing error mid-frame aborts silently.
    send_byte(W); send_byte(8'h10); send_byte(8'h00, 1'b1);
    @(negedge clk);
    chk("rxerr_idle", busy, 0);
    chk("rxerr_no_tx", tx_valid, 0);

`ifdef UART_DBG_TIMEOUT_EN
    force_rem = 1000;
    send_frame(R, 32'h30, 0); wait_idle();
    force_rem = -1;
`endif

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 5) == 0) a[7:4] = 4'hF;
      if ($urandom_range(0, 7) == 0) a[31:16] = 16'($urandom);
      if (op < 8 && $urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (op < 4) send_frame(W, a, $urandom);
      else if (op < 8) send_frame(R, a, 0);
      else if (op == 8) begin
        rx_data = 8'($urandom);
        if (rx_data == W || rx_data == R) rx_data = 8'h00;
        send_frame(rx_data, 0, 0);
      end else begin
        nb = $urandom_range(0, 3);
        send_byte(($urandom_range(0, 1) != 0) ? W : R);
        for (int i = 0; i < nb; i++) send_byte(8'($urandom) & 8'hFC);
        send_byte(8'($urandom), 1'b1);
      end
      wait_idle();
    end

    // Asynchronous reset during a stalled access.
    force_rem = 1000;
    exp_bus.push_back('{32'h40, 1'b0, 32'h0});
    send_byte(R);
    for (int i = 0; i < 4; i++) send_byte(8'(32'h40 >> (8 * i)));
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_bus", {bus_wen, bus_ren, bus_addr, bus_wdata, bus_strobe}, 0);
    chk("rst_mid_tx", {tx_valid, tx_data, dropped, busy}, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0; force_rem = -1;
    send_frame(R, 32'h4, 0); wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
